// File: rtl/mac_wr_req_arb.sv
// N-channel write-request front end: QoS/round-robin arbitration, local burst
// buffering, then replay of request and data onto one downstream write channel.
module mac_wr_req_arb #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int ID_W   = 3,
    parameter int QOS_W  = 4,
    parameter int LEN_W  = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            iValidWr,
    input  logic [NUM_CH*ADDR_W-1:0]     iAddrWr,
    input  logic [NUM_CH*TAG_W-1:0]      iTagWr,
    input  logic [NUM_CH*ID_W-1:0]       iIdWr,
    input  logic [NUM_CH*LEN_W-1:0]      iLenWr,
    input  logic [NUM_CH*QOS_W-1:0]      iQoSWr,
    output logic [NUM_CH-1:0]            oReadyWr,
    input  logic [NUM_CH-1:0]            iDataValid,
    input  logic [NUM_CH*DATA_W-1:0]     iDataWr,
    input  logic [NUM_CH*DATA_W/8-1:0]   iMaskWr,
    input  logic [NUM_CH-1:0]            iEoD,
    output logic [NUM_CH-1:0]            oDataReady,
    output logic                         oValid,
    output logic [ADDR_W-1:0]            oAddr,
    output logic [TAG_W-1:0]             oTag,
    output logic [ID_W-1:0]              oId,
    output logic [LEN_W-1:0]             oLen,
    output logic [QOS_W-1:0]             oQoS,
    input  logic                         iReady,
    output logic                         oDataValid,
    output logic [DATA_W-1:0]            oData,
    output logic [DATA_W/8-1:0]          oMask,
    output logic                         oEoD,
    input  logic                         iDataReady,
    output logic                         oLenErr,
    output logic [$clog2(NUM_CH)-1:0]    oGrantCh
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DEPTH  = 2 ** LEN_W;

    typedef enum logic [2:0] {IDLE, GRANT, DATA, ISSUE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     win_q, win_d, rr_q, rr_d, arb_win, idx;
    logic [CH_W:0]       sum;
    logic                found;
    logic [QOS_W-1:0]    best;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [QOS_W-1:0]    qos_q, qos_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d, rd_q, rd_d;
    logic                dbeat, eod_in, last_cnt;

    logic [DATA_W-1:0]   buf_data_q [DEPTH];
    logic [MASK_W-1:0]   buf_mask_q [DEPTH];

    logic [ADDR_W-1:0]   ch_addr [NUM_CH];
    logic [TAG_W-1:0]    ch_tag  [NUM_CH];
    logic [ID_W-1:0]     ch_id   [NUM_CH];
    logic [LEN_W-1:0]    ch_len  [NUM_CH];
    logic [QOS_W-1:0]    ch_qos  [NUM_CH];
    logic [DATA_W-1:0]   ch_data [NUM_CH];
    logic [MASK_W-1:0]   ch_mask [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr[i] = iAddrWr[i*ADDR_W +: ADDR_W];
            ch_tag[i]  = iTagWr[i*TAG_W +: TAG_W];
            ch_id[i]   = iIdWr[i*ID_W +: ID_W];
            ch_len[i]  = iLenWr[i*LEN_W +: LEN_W];
            ch_qos[i]  = iQoSWr[i*QOS_W +: QOS_W];
            ch_data[i] = iDataWr[i*DATA_W +: DATA_W];
            ch_mask[i] = iMaskWr[i*MASK_W +: MASK_W];
        end
    end

    // Walk channels starting at rr_q; a strict '>' keeps the first of equal QoS.
    always_comb begin
        arb_win = '0;
        found   = 1'b0;
        best    = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rr_q} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH))
                sum = sum - (CH_W+1)'(NUM_CH);
            idx = sum[CH_W-1:0];
            if (iValidWr[idx] && (!found || ch_qos[idx] > best)) begin
                found   = 1'b1;
                best    = ch_qos[idx];
                arb_win = idx;
            end
        end
    end

    assign dbeat    = (state_q == DATA) && iDataValid[win_q];
    assign eod_in   = iEoD[win_q];
    assign last_cnt = (cnt_q == len_q);
    // Early EoD and a missing EoD on the final beat are both length errors.
    assign oLenErr  = dbeat && (eod_in != last_cnt);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        id_d       = id_q;
        len_d      = len_q;
        qos_d      = qos_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        oReadyWr   = '0;
        oDataReady = '0;
        oValid     = 1'b0;
        oDataValid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|iValidWr) begin
                    win_d   = arb_win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                oReadyWr[win_q] = 1'b1;
                addr_d  = ch_addr[win_q];
                tag_d   = ch_tag[win_q];
                id_d    = ch_id[win_q];
                len_d   = ch_len[win_q];
                qos_d   = ch_qos[win_q];
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                oDataReady[win_q] = 1'b1;
                if (dbeat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (eod_in || last_cnt) begin
                        len_d   = cnt_q;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                oValid = 1'b1;
                if (iReady) begin
                    rd_d    = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                oDataValid = 1'b1;
                if (iDataReady) begin
                    if (rd_q == len_q) begin
                        rr_d    = (win_q == CH_W'(NUM_CH-1)) ? '0 : win_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            win_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
            id_q    <= '0;
            len_q   <= '0;
            qos_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            id_q    <= id_d;
            len_q   <= len_d;
            qos_q   <= qos_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Buffer contents need no reset; stale entries are never presented.
    always_ff @(posedge clk) begin
        if (dbeat) begin
            buf_data_q[cnt_q] <= ch_data[win_q];
            buf_mask_q[cnt_q] <= ch_mask[win_q];
        end
    end

    assign oAddr    = addr_q;
    assign oTag     = tag_q;
    assign oId      = id_q;
    assign oLen     = len_q;
    assign oQoS     = qos_q;
    assign oGrantCh = win_q;
    assign oData    = oDataValid ? buf_data_q[rd_q] : '0;
    assign oMask    = oDataValid ? buf_mask_q[rd_q] : '0;
    assign oEoD     = oDataValid && (rd_q == len_q);

endmodule

// File: tb/tb_mac_wr_req_arb.sv
// Directed bench for mac_wr_req_arb: per-channel requester models, a downstream
// sink with stall/toggle patterns, and scenario tasks with inline checks.
module tb_mac_wr_req_arb;
    localparam int N = 4, AW = 32, DW = 32, TW = 4, IW = 3, QW = 4, LW = 2, MW = 4;

    typedef struct packed {
        logic [AW-1:0] addr; logic [TW-1:0] tag; logic [IW-1:0] id;
        logic [LW-1:0] len;  logic [QW-1:0] qos;
    } req_t;
    typedef struct packed { logic [DW-1:0] data; logic [MW-1:0] mask; logic eod; } beat_t;

    logic clk = 1'b0, resetn = 1'b0;
    logic [N-1:0] iValidWr = '0, oReadyWr, iDataValid = '0, iEoD = '0, oDataReady;
    logic [N*AW-1:0] iAddrWr = '0;
    logic [N*TW-1:0] iTagWr = '0;
    logic [N*IW-1:0] iIdWr = '0;
    logic [N*LW-1:0] iLenWr = '0;
    logic [N*QW-1:0] iQoSWr = '0;
    logic [N*DW-1:0] iDataWr = '0;
    logic [N*MW-1:0] iMaskWr = '0;
    logic oValid, iReady = 1'b1, oDataValid, oEoD, iDataReady = 1'b1, oLenErr;
    logic [AW-1:0] oAddr; logic [TW-1:0] oTag; logic [IW-1:0] oId;
    logic [LW-1:0] oLen;  logic [QW-1:0] oQoS; logic [DW-1:0] oData; logic [MW-1:0] oMask;
    logic [1:0] oGrantCh;

    mac_wr_req_arb dut (
        .clk(clk), .resetn(resetn),
        .iValidWr(iValidWr), .iAddrWr(iAddrWr), .iTagWr(iTagWr), .iIdWr(iIdWr),
        .iLenWr(iLenWr), .iQoSWr(iQoSWr), .oReadyWr(oReadyWr),
        .iDataValid(iDataValid), .iDataWr(iDataWr), .iMaskWr(iMaskWr), .iEoD(iEoD),
        .oDataReady(oDataReady),
        .oValid(oValid), .oAddr(oAddr), .oTag(oTag), .oId(oId), .oLen(oLen), .oQoS(oQoS),
        .iReady(iReady), .oDataValid(oDataValid), .oData(oData), .oMask(oMask),
        .oEoD(oEoD), .iDataReady(iDataReady), .oLenErr(oLenErr), .oGrantCh(oGrantCh)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;

    // requester model state: ph 0 idle, 1 requesting, 2 sending beats
    int ph[N], bi[N], nb[N], eat[N], reps[N];
    logic [AW-1:0] r_addr[N]; logic [TW-1:0] r_tag[N]; logic [IW-1:0] r_id[N];
    logic [LW-1:0] r_len[N];  logic [QW-1:0] r_qos[N]; logic [MW-1:0] r_mask[N];
    logic [DW-1:0] r_data[N][4];

    // downstream sink controls and logs
    int stall_left = 0; logic tog_mode = 1'b0, tog_val = 1'b1;
    int gq[$]; req_t rq[$]; beat_t bq[$];
    int rdy_bad, lenerr, nacc, stall_cnt, unstable, t_rdy, t_beat0, t_valid, t_dv;
    req_t snap, cur; logic snap_v;

    task automatic clear_logs();
        gq.delete(); rq.delete(); bq.delete();
        rdy_bad = 0; lenerr = 0; nacc = 0; stall_cnt = 0; unstable = 0; snap_v = 1'b0;
        t_rdy = -1; t_beat0 = -1; t_valid = -1; t_dv = -1;
    endtask

    task automatic drive_inputs();
        for (int ch = 0; ch < N; ch++) begin
            iValidWr[ch]            = (ph[ch] == 1);
            iAddrWr[ch*AW +: AW]    = r_addr[ch];
            iTagWr[ch*TW +: TW]     = r_tag[ch];
            iIdWr[ch*IW +: IW]      = r_id[ch];
            iLenWr[ch*LW +: LW]     = r_len[ch];
            iQoSWr[ch*QW +: QW]     = r_qos[ch];
            iDataValid[ch]          = (ph[ch] == 2);
            iDataWr[ch*DW +: DW]    = r_data[ch][bi[ch]];
            iMaskWr[ch*MW +: MW]    = r_mask[ch];
            iEoD[ch]                = (ph[ch] == 2) && (bi[ch] == eat[ch]);
        end
        iReady     = (stall_left == 0);
        iDataReady = tog_mode ? tog_val : 1'b1;
    endtask

    task automatic idle_reqs();
        for (int ch = 0; ch < N; ch++) begin
            ph[ch] = 0; bi[ch] = 0; nb[ch] = 1; eat[ch] = -1; reps[ch] = 0;
            r_addr[ch] = '0; r_tag[ch] = '0; r_id[ch] = '0; r_len[ch] = '0;
            r_qos[ch] = '0; r_mask[ch] = '0;
            for (int k = 0; k < 4; k++) r_data[ch][k] = '0;
        end
        drive_inputs();
    endtask

    task automatic load(input int ch, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                        input logic [IW-1:0] id, input logic [LW-1:0] len,
                        input logic [QW-1:0] qos, input int n, input int e, input int rp,
                        input logic [DW-1:0] base, input logic [DW-1:0] dstep,
                        input logic [MW-1:0] mask);
        r_addr[ch] = addr; r_tag[ch] = tag; r_id[ch] = id; r_len[ch] = len;
        r_qos[ch] = qos; r_mask[ch] = mask; nb[ch] = n; eat[ch] = e; reps[ch] = rp;
        for (int k = 0; k < 4; k++) r_data[ch][k] = base + dstep * k;
        bi[ch] = 0; ph[ch] = 1;
        drive_inputs();
    endtask

    // Called at negedge+1: observe settled outputs, cross the posedge, update drivers.
    task automatic step();
        logic [N-1:0] hr, hd;
        hr = oReadyWr & iValidWr;
        hd = oDataReady & iDataValid;
        if (oReadyWr != '0) begin
            gq.push_back(int'(oGrantCh));
            if (oReadyWr != (4'b0001 << oGrantCh)) rdy_bad++;
            if (t_rdy < 0) t_rdy = cyc;
        end
        if (hd != '0) begin nacc++; if (t_beat0 < 0) t_beat0 = cyc; end
        if (oValid) begin
            if (t_valid < 0) t_valid = cyc;
            cur.addr = oAddr; cur.tag = oTag; cur.id = oId; cur.len = oLen; cur.qos = oQoS;
            if (!snap_v) begin snap = cur; snap_v = 1'b1; end
            else if (cur !== snap) unstable++;
            if (iReady) begin rq.push_back(cur); snap_v = 1'b0; end
            else stall_cnt++;
        end
        if (oDataValid && t_dv < 0) t_dv = cyc;
        if (oDataValid && iDataReady) bq.push_back({oData, oMask, oEoD});
        if (oLenErr) lenerr++;
        if (oValid && stall_left > 0) stall_left--;
        @(negedge clk);
        cyc++;
        for (int ch = 0; ch < N; ch++) begin
            if (hr[ch]) begin ph[ch] = 2; bi[ch] = 0; end
            else if (hd[ch]) begin
                if (bi[ch] == nb[ch] - 1) begin
                    if (reps[ch] > 0) begin reps[ch]--; ph[ch] = 1; end
                    else ph[ch] = 0;
                    bi[ch] = 0;
                end else bi[ch]++;
            end
        end
        if (tog_mode) tog_val = ~tog_val;
        drive_inputs();
        #1;
    endtask

    task automatic run(input int n, input int budget);
        for (int k = 0; k < budget && bq.size() < n; k++) step();
        repeat (3) step();
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        idle_reqs();
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        total++; if (oReadyWr !== 4'b0 || oDataReady !== 4'b0) begin bad++;
            $display("FAIL rst_ready got=%b/%b exp=0000/0000", oReadyWr, oDataReady); end
        total++; if (oValid !== 1'b0 || oDataValid !== 1'b0 || oEoD !== 1'b0 || oLenErr !== 1'b0) begin bad++;
            $display("FAIL rst_valid got=%b%b%b%b exp=0000", oValid, oDataValid, oEoD, oLenErr); end
        total++; if (oGrantCh !== 2'd0 || oAddr !== 32'h0 || oLen !== 2'd0 || oData !== 32'h0) begin bad++;
            $display("FAIL rst_fields grant=%0d addr=%h len=%0d data=%h exp=0", oGrantCh, oAddr, oLen, oData); end
        @(negedge clk); resetn = 1'b1; #1;
        step();
        total++; if (oValid !== 1'b0 || oReadyWr !== 4'b0) begin bad++;
            $display("FAIL rst_idle got=%b/%b exp=0/0000", oValid, oReadyWr); end
    endtask

    task automatic test_basic();
        int c0;
        clear_logs();
        c0 = cyc;
        load(1, 32'h2345_F220, 4'hA, 3'd5, 2'b01, 4'd6, 2, 1, 0, 32'hABCD_EF12, 32'h2000_0000, 4'hF);
        run(2, 40);
        total++; if (gq.size() !== 1 || gq[0] !== 1 || rdy_bad !== 0) begin bad++;
            $display("FAIL t1_grant n=%0d ch=%0d onehot_err=%0d exp=1/1/0", gq.size(), gq[0], rdy_bad); end
        total++; if (t_rdy - c0 !== 1 || t_beat0 - c0 !== 2 || t_valid - c0 !== 4 || t_dv - c0 !== 5) begin bad++;
            $display("FAIL t1_latency rdy=%0d beat=%0d valid=%0d dv=%0d exp=1/2/4/5",
                     t_rdy - c0, t_beat0 - c0, t_valid - c0, t_dv - c0); end
        total++; if (rq.size() !== 1 || rq[0] !== req_t'{32'h2345_F220, 4'hA, 3'd5, 2'b01, 4'd6}) begin bad++;
            $display("FAIL t1_req got=%h exp=%h", rq[0], req_t'{32'h2345_F220, 4'hA, 3'd5, 2'b01, 4'd6}); end
        total++; if (bq.size() !== 2 || bq[0] !== {32'hABCD_EF12, 4'hF, 1'b0} || bq[1] !== {32'hCBCD_EF12, 4'hF, 1'b1}) begin bad++;
            $display("FAIL t1_beats n=%0d b0=%h b1=%h exp=abcdef12f0/cbcdef12f1", bq.size(), bq[0], bq[1]); end
        total++; if (lenerr !== 0) begin bad++; $display("FAIL t1_lenerr got=%0d exp=0", lenerr); end
    endtask

    task automatic test_qos();
        clear_logs();
        load(0, 32'h0000_1000, 4'h1, 3'd0, 2'b00, 4'd2, 1, 0, 0, 32'h1111_0000, 32'h0, 4'h5);
        load(3, 32'h0000_3000, 4'h3, 3'd3, 2'b00, 4'd9, 1, 0, 0, 32'h3333_0000, 32'h0, 4'hA);
        run(2, 60);
        total++; if (gq.size() !== 2 || gq[0] !== 3 || gq[1] !== 0) begin bad++;
            $display("FAIL t2_order n=%0d g0=%0d g1=%0d exp=2/3/0", gq.size(), gq[0], gq[1]); end
        total++; if (rq.size() !== 2 || rq[0].addr !== 32'h3000 || rq[0].qos !== 4'd9 || rq[1].addr !== 32'h1000) begin bad++;
            $display("FAIL t2_req n=%0d a0=%h q0=%0d a1=%h exp=3000/9/1000", rq.size(), rq[0].addr, rq[0].qos, rq[1].addr); end
        total++; if (bq.size() !== 2 || bq[0] !== {32'h3333_0000, 4'hA, 1'b1} || bq[1] !== {32'h1111_0000, 4'h5, 1'b1}) begin bad++;
            $display("FAIL t2_beats b0=%h b1=%h exp=33330000a1/1111000051", bq[0], bq[1]); end
    endtask

    task automatic test_rr();
        apply_reset();
        clear_logs();
        load(0, 32'h0000_0A00, 4'h0, 3'd1, 2'b00, 4'd4, 1, 0, 1, 32'h0A0A_0000, 32'h0, 4'hF);
        load(2, 32'h0000_0C00, 4'h2, 3'd2, 2'b00, 4'd4, 1, 0, 1, 32'h0C0C_0000, 32'h0, 4'hF);
        run(4, 120);
        total++; if (gq.size() !== 4 || gq[0] !== 0 || gq[1] !== 2 || gq[2] !== 0 || gq[3] !== 2) begin bad++;
            $display("FAIL t3_rr n=%0d seq=%0d%0d%0d%0d exp=0202", gq.size(), gq[0], gq[1], gq[2], gq[3]); end
        total++; if (bq.size() !== 4 || bq[1].data !== 32'h0C0C_0000 || bq[2].data !== 32'h0A0A_0000) begin bad++;
            $display("FAIL t3_beats n=%0d b1=%h b2=%h exp=4/0c0c0000/0a0a0000", bq.size(), bq[1].data, bq[2].data); end
    endtask

    task automatic test_len_err();
        clear_logs();
        load(1, 32'h0000_4400, 4'h4, 3'd4, 2'b11, 4'd1, 2, 1, 0, 32'h4000_0001, 32'h1, 4'h3);
        run(2, 40);
        total++; if (rq.size() !== 1 || rq[0].len !== 2'b01) begin bad++;
            $display("FAIL t4a_len n=%0d len=%0d exp=1/1", rq.size(), rq[0].len); end
        total++; if (bq.size() !== 2 || bq[0] !== {32'h4000_0001, 4'h3, 1'b0} || bq[1] !== {32'h4000_0002, 4'h3, 1'b1}) begin bad++;
            $display("FAIL t4a_beats n=%0d b0=%h b1=%h exp=4000000130/4000000231", bq.size(), bq[0], bq[1]); end
        total++; if (lenerr !== 1) begin bad++; $display("FAIL t4a_lenerr got=%0d exp=1", lenerr); end
        clear_logs();
        load(0, 32'h0000_5500, 4'h5, 3'd6, 2'b00, 4'd1, 1, -1, 0, 32'h5000_0005, 32'h0, 4'hC);
        run(1, 40);
        total++; if (rq.size() !== 1 || rq[0].len !== 2'b00 || bq.size() !== 1 || bq[0] !== {32'h5000_0005, 4'hC, 1'b1}) begin bad++;
            $display("FAIL t4b_beat nreq=%0d len=%0d n=%0d b0=%h exp=1/0/1/50000005c1", rq.size(), rq[0].len, bq.size(), bq[0]); end
        total++; if (lenerr !== 1) begin bad++; $display("FAIL t4b_lenerr got=%0d exp=1", lenerr); end
    endtask

    task automatic test_backpressure();
        clear_logs();
        stall_left = 5; tog_mode = 1'b1; tog_val = 1'b1;
        load(3, 32'h0000_7700, 4'h7, 3'd7, 2'b11, 4'd3, 4, 3, 0, 32'h7000_0000, 32'h11, 4'h9);
        run(4, 80);
        tog_mode = 1'b0; drive_inputs();
        total++; if (stall_cnt !== 5 || unstable !== 0) begin bad++;
            $display("FAIL t5_stall cycles=%0d unstable=%0d exp=5/0", stall_cnt, unstable); end
        total++; if (rq.size() !== 1 || rq[0] !== req_t'{32'h7700, 4'h7, 3'd7, 2'b11, 4'd3}) begin bad++;
            $display("FAIL t5_req n=%0d got=%h", rq.size(), rq[0]); end
        total++; if (bq.size() !== 4) begin bad++; $display("FAIL t5_nbeats got=%0d exp=4", bq.size()); end
        for (int k = 0; k < 4 && k < bq.size(); k++) begin
            total++;
            if (bq[k] !== {32'h7000_0000 + 32'h11 * k, 4'h9, (k == 3)}) begin bad++;
                $display("FAIL t5_beat%0d got=%h exp=%h", k, bq[k], {32'h7000_0000 + 32'h11 * k, 4'h9, (k == 3)}); end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        load(1, 32'h0000_8800, 4'h8, 3'd1, 2'b11, 4'd5, 4, 3, 0, 32'hDEAD_0000, 32'h1, 4'hF);
        for (int k = 0; k < 20 && nacc < 1; k++) step();
        total++; if (oDataReady !== 4'b0010) begin bad++;
            $display("FAIL t6_in_data got=%b exp=0010", oDataReady); end
        resetn = 1'b0;
        #1;
        total++; if (oReadyWr !== 4'b0 || oDataReady !== 4'b0 || oValid !== 1'b0 || oDataValid !== 1'b0 || oLenErr !== 1'b0) begin bad++;
            $display("FAIL t6_async_rst got=%b/%b/%b%b%b exp=0", oReadyWr, oDataReady, oValid, oDataValid, oLenErr); end
        total++; if (oGrantCh !== 2'd0 || oAddr !== 32'h0) begin bad++;
            $display("FAIL t6_rst_fields grant=%0d addr=%h exp=0/0", oGrantCh, oAddr); end
        idle_reqs();
        @(negedge clk); @(negedge clk);
        resetn = 1'b1; #1;
        clear_logs();
        load(2, 32'h0000_9900, 4'h9, 3'd2, 2'b01, 4'd0, 2, 1, 0, 32'hBEEF_0000, 32'h1, 4'h6);
        run(2, 40);
        total++; if (gq.size() !== 1 || gq[0] !== 2 || rq.size() !== 1 || rq[0].addr !== 32'h9900) begin bad++;
            $display("FAIL t6_after ng=%0d g=%0d nr=%0d addr=%h exp=1/2/1/9900", gq.size(), gq[0], rq.size(), rq[0].addr); end
        total++; if (bq.size() !== 2 || bq[0] !== {32'hBEEF_0000, 4'h6, 1'b0} || bq[1] !== {32'hBEEF_0001, 4'h6, 1'b1}) begin bad++;
            $display("FAIL t6_beats n=%0d b0=%h b1=%h exp=beef000060/beef000161", bq.size(), bq[0], bq[1]); end
    endtask

    initial begin
        idle_reqs();
        clear_logs();
        @(negedge clk); #1;
        test_reset();
        test_basic();
        test_qos();
        test_rr();
        test_len_err();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
